// File: rtl/mem_access_pkg.sv
// Shared types and defaults for the memory-access stage.
package mem_access_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} mau_state_t;

  localparam int DEFAULT_N        = 64;
  localparam int DEFAULT_ADDR_LSB = 3;

  function automatic logic is_mem_op(input logic rd, input logic wr);
    return rd | wr;
  endfunction

endpackage

// File: rtl/mau_req_reg.sv
// Capture registers for the outgoing data-memory request (we, address, store data).
module mau_req_reg
  import mem_access_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic         i_we,
  input  logic [N-1:0] i_addr,
  input  logic [N-1:0] i_wdata,
  output logic         o_we,
  output logic [N-1:0] o_addr,
  output logic [N-1:0] o_wdata
);

  logic         r_we;
  logic [N-1:0] r_addr;
  logic [N-1:0] r_wdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (i_load) begin
      r_we    <= i_we;
      r_addr  <= i_addr;
      r_wdata <= i_wdata;
    end
  end

  assign o_we    = r_we;
  assign o_addr  = r_addr;
  assign o_wdata = r_wdata;

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: runs one data-memory access per op over valid/ready, stalls upstream meanwhile,
// and resolves the branch decision. Optional misaligned-access trap under `MISALIGN_TRAP_EN.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int N        = DEFAULT_N,
  parameter int ADDR_LSB = DEFAULT_ADDR_LSB
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         op_valid,
  input  logic         MemRead,
  input  logic         MemWrite,
  input  logic         Branch,
  input  logic         zero_M,
  input  logic [N-1:0] aluResult_M,
  input  logic [N-1:0] writeData_M,
  input  logic [N-1:0] PCBranch_M,
  output logic         PCSrc_M,
  output logic [N-1:0] PCBranch_out,
  output logic         stall_M,
  output logic [N-1:0] readData_M,
  output logic         rd_valid,
  output logic         dm_req_valid,
  input  logic         dm_req_ready,
  output logic         dm_req_we,
  output logic [N-1:0] dm_req_addr,
  output logic [N-1:0] dm_req_wdata,
  input  logic         dm_resp_valid,
  input  logic [N-1:0] dm_resp_rdata,
  output logic         fault
);

  if (ADDR_LSB < 1 || ADDR_LSB >= N) begin : g_bad_addr_lsb
    $error("mem_access_unit: ADDR_LSB out of range");
  end

  mau_state_t   r_state;
  mau_state_t   w_state_next;
  logic [N-1:0] r_read_data;
  logic         w_mem_op;
  logic         w_capture;

  assign w_mem_op  = op_valid & is_mem_op(MemRead, MemWrite);
  assign w_capture = (r_state == IDLE) & w_mem_op;

`ifdef MISALIGN_TRAP_EN
  logic w_misaligned;
  logic r_fault;

  assign w_misaligned = |aluResult_M[ADDR_LSB-1:0];

  // Only high during the DONE cycle that follows a trapped op.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_fault <= 1'b0;
    else        r_fault <= w_capture & w_misaligned;
  end

  assign fault = (r_state == DONE) & r_fault;
`else
  assign fault = 1'b0;
`endif

  // MemWrite wins when both flags are set, so it alone selects the direction.
  mau_req_reg #(.N(N)) u_req_reg (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_capture),
    .i_we    (MemWrite),
    .i_addr  (aluResult_M),
    .i_wdata (writeData_M),
    .o_we    (dm_req_we),
    .o_addr  (dm_req_addr),
    .o_wdata (dm_req_wdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    dm_req_valid = 1'b0;
    stall_M      = 1'b0;
    rd_valid     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_mem_op) begin
          stall_M = 1'b1;
`ifdef MISALIGN_TRAP_EN
          w_state_next = w_misaligned ? DONE : REQ;
`else
          w_state_next = REQ;
`endif
        end
      end
      REQ: begin
        dm_req_valid = 1'b1;
        stall_M      = 1'b1;
        if (dm_req_ready) w_state_next = dm_req_we ? DONE : WAIT;
      end
      WAIT: begin
        stall_M = 1'b1;
        if (dm_resp_valid) w_state_next = DONE;
      end
      DONE: begin
`ifdef MISALIGN_TRAP_EN
        rd_valid = ~dm_req_we & ~r_fault;
`else
        rd_valid = ~dm_req_we;
`endif
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                r_read_data <= '0;
    else if (r_state == WAIT && dm_resp_valid) r_read_data <= dm_resp_rdata;
  end

  assign readData_M   = r_read_data;
  assign PCSrc_M      = Branch & zero_M & op_valid;
  assign PCBranch_out = PCBranch_M;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: driver pushes expectations, monitor pops on DUT outputs.
module tb_mem_access_unit;

  localparam int N        = 64;
  localparam int ADDR_LSB = 3;

  logic         clk;
  logic         reset;
  logic         op_valid, MemRead, MemWrite, Branch, zero_M;
  logic [N-1:0] aluResult_M, writeData_M, PCBranch_M;
  logic         PCSrc_M, stall_M, rd_valid, fault;
  logic [N-1:0] PCBranch_out, readData_M;
  logic         dm_req_valid, dm_req_ready, dm_req_we;
  logic [N-1:0] dm_req_addr, dm_req_wdata;
  logic         dm_resp_valid;
  logic [N-1:0] dm_resp_rdata;

  mem_access_unit #(.N(N), .ADDR_LSB(ADDR_LSB)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .MemRead(MemRead), .MemWrite(MemWrite),
    .Branch(Branch), .zero_M(zero_M), .aluResult_M(aluResult_M), .writeData_M(writeData_M),
    .PCBranch_M(PCBranch_M), .PCSrc_M(PCSrc_M), .PCBranch_out(PCBranch_out), .stall_M(stall_M),
    .readData_M(readData_M), .rd_valid(rd_valid), .dm_req_valid(dm_req_valid),
    .dm_req_ready(dm_req_ready), .dm_req_we(dm_req_we), .dm_req_addr(dm_req_addr),
    .dm_req_wdata(dm_req_wdata), .dm_resp_valid(dm_resp_valid), .dm_resp_rdata(dm_resp_rdata),
    .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         we;
    logic [N-1:0] addr;
    logic [N-1:0] wdata;
  } req_t;

  int           checks = 0;
  int           failures = 0;
  req_t         exp_req_q[$];
  logic [N-1:0] exp_rd_q[$];
  int           exp_fault_cnt = 0;
  int           req_valid_cycles = 0;
  logic [N-1:0] model_mem[logic [N-1:0]];
  logic [N-1:0] resp_mem[logic [N-1:0]];
  int           cfg_ready_dly = 0;
  int           cfg_resp_dly = 0;
  bit           cfg_spurious = 0;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    checks++;
    failures++;
    $display("FAIL %s %s", name, what);
  endtask

  // Contents of a never-written memory word.
  function automatic logic [N-1:0] dflt(input logic [N-1:0] a);
    return (a * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0123_4567_89AB_CDEF;
  endfunction

  function automatic logic [N-1:0] model_read(input logic [N-1:0] a);
    return model_mem.exists(a) ? model_mem[a] : dflt(a);
  endfunction

  // Memory responder: ready after cfg_ready_dly cycles, read data cfg_resp_dly cycles after accept.
  initial begin
    bit           pend;
    int           rcnt, wcnt;
    logic [N-1:0] paddr;
    pend = 0; rcnt = 0; wcnt = 0; paddr = '0;
    dm_req_ready = 1'b0; dm_resp_valid = 1'b0; dm_resp_rdata = '0;
    forever begin
      @(negedge clk);
      dm_resp_valid = 1'b0;
      if (pend) begin
        if (rcnt == 0) begin
          dm_resp_valid = 1'b1;
          dm_resp_rdata = resp_mem.exists(paddr) ? resp_mem[paddr] : dflt(paddr);
          pend = 0;
        end else rcnt--;
      end else if (cfg_spurious && $urandom_range(0, 3) == 0) begin
        dm_resp_valid = 1'b1;
        dm_resp_rdata = {$urandom(), $urandom()};
      end
      dm_req_ready = 1'b0;
      if (dm_req_valid) begin
        if (wcnt >= cfg_ready_dly) begin
          dm_req_ready = 1'b1;
          wcnt = 0;
          if (dm_req_we) resp_mem[dm_req_addr] = dm_req_wdata;
          else begin
            pend = 1; paddr = dm_req_addr; rcnt = cfg_resp_dly;
          end
        end else wcnt++;
      end else wcnt = 0;
    end
  end

  // Monitor: samples just after the falling edge, when responder and DUT outputs have settled.
  initial begin
    logic [N-1:0] last_rd, prev_addr, prev_wdata;
    logic         prev_we;
    bit           prev_wait;
    req_t         r;
    last_rd = '0; prev_addr = '0; prev_wdata = '0; prev_we = 1'b0; prev_wait = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!reset) begin
        last_rd = '0;
        prev_wait = 0;
      end else begin
        check("pcsrc", {63'd0, PCSrc_M}, {63'd0, Branch & zero_M & op_valid});
        check("pcbranch", PCBranch_out, PCBranch_M);
        if (dm_req_valid) req_valid_cycles++;
        if (prev_wait && dm_req_valid) begin
          check("req_addr_stable", dm_req_addr, prev_addr);
          check("req_we_stable", {63'd0, dm_req_we}, {63'd0, prev_we});
          check("req_wdata_stable", dm_req_wdata, prev_wdata);
        end
        prev_wait  = dm_req_valid && !dm_req_ready;
        prev_addr  = dm_req_addr;
        prev_we    = dm_req_we;
        prev_wdata = dm_req_wdata;
        if (dm_req_valid && dm_req_ready) begin
          if (exp_req_q.size() == 0) fail_now("req_unexpected", $sformatf("actual addr=0x%0h required=no request", dm_req_addr));
          else begin
            r = exp_req_q.pop_front();
            check("req_we", {63'd0, dm_req_we}, {63'd0, r.we});
            check("req_addr", dm_req_addr, r.addr);
            if (r.we) check("req_wdata", dm_req_wdata, r.wdata);
          end
        end
        if (rd_valid) begin
          if (exp_rd_q.size() == 0) fail_now("rd_unexpected", $sformatf("actual readData=0x%0h required=no rd_valid", readData_M));
          else check("rd_data", readData_M, exp_rd_q.pop_front());
          last_rd = readData_M;
        end else begin
          check("rd_hold", readData_M, last_rd);
        end
        if (fault) begin
          if (exp_fault_cnt == 0) fail_now("fault_unexpected", "actual fault=1 required=0");
          else begin
            checks++;
            exp_fault_cnt--;
          end
        end
      end
    end
  end

  int op_num = 0;

  task automatic run_op(input string tag, input bit rd, input bit wr, input bit br, input bit zr,
                        input logic [N-1:0] addr, input logic [N-1:0] wdata, input logic [N-1:0] pcb,
                        input int rdly, input int sdly);
    bit   is_mem, trapped, timed_out;
    int   exp_stall, exp_vc, stall_n, vc0;
    req_t r;
    is_mem  = rd | wr;
    trapped = 0;
`ifdef MISALIGN_TRAP_EN
    trapped = is_mem && (addr[ADDR_LSB-1:0] != '0);
`endif
    cfg_ready_dly = rdly;
    cfg_resp_dly  = sdly;
    if (is_mem && !trapped) begin
      r.we = wr; r.addr = addr; r.wdata = wdata;
      exp_req_q.push_back(r);
      if (wr) model_mem[addr] = wdata;
      else    exp_rd_q.push_back(model_read(addr));
      exp_stall = 2 + rdly + (wr ? 0 : sdly + 1);
      exp_vc    = rdly + 1;
    end else if (trapped) begin
      exp_fault_cnt++;
      exp_stall = 1;
      exp_vc    = 0;
    end else begin
      exp_stall = 0;
      exp_vc    = 0;
    end
    vc0 = req_valid_cycles;
    op_valid = 1'b1; MemRead = rd; MemWrite = wr; Branch = br; zero_M = zr;
    aluResult_M = addr; writeData_M = wdata; PCBranch_M = pcb;
    stall_n = 0;
    timed_out = 1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      #1;
      if (!stall_M) begin
        timed_out = 0;
        break;
      end
      stall_n++;
    end
    if (timed_out) fail_now({tag, "_timeout"}, "actual stall_M stuck at 1 required=release within 300 cycles");
    @(posedge clk);
    #1;
    check({tag, "_stall_cycles"}, stall_n, exp_stall);
    check({tag, "_req_valid_cycles"}, req_valid_cycles - vc0, exp_vc);
    $display("op %0d %s rd=%0b wr=%0b br=%0b addr=0x%0h stall=%0d", op_num, tag, rd, wr, br, addr, stall_n);
    op_num++;
    op_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Branch = 1'b0; zero_M = 1'b0;
  endtask

  initial begin
    logic [N-1:0] a;
    int           kind;
    bit           timed_out;
    reset = 1'b0;
    op_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Branch = 1'b0; zero_M = 1'b0;
    aluResult_M = '0; writeData_M = '0; PCBranch_M = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_valid", {63'd0, dm_req_valid}, 0);
    check("rst_stall", {63'd0, stall_M}, 0);
    check("rst_rd_valid", {63'd0, rd_valid}, 0);
    check("rst_read_data", readData_M, 0);
    check("rst_req_addr", dm_req_addr, 0);
    check("rst_req_wdata", dm_req_wdata, 0);
    check("rst_req_we", {63'd0, dm_req_we}, 0);
    check("rst_fault", {63'd0, fault}, 0);
    check("rst_pcsrc", {63'd0, PCSrc_M}, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    run_op("store_0x40", 0, 1, 0, 0, 64'h40, 64'hDEAD, 64'h0, 0, 0);
    run_op("store_0x88", 0, 1, 0, 0, 64'h88, 64'h1234, 64'h0, 0, 0);
    run_op("load_0x88", 1, 0, 0, 0, 64'h88, 64'h0, 64'h0, 3, 2);
    check("load_0x88_data", readData_M, 64'h1234);
    run_op("branch_taken", 0, 0, 1, 1, 64'h0, 64'h0, 64'h100, 0, 0);
    run_op("rd_and_wr", 1, 1, 0, 0, 64'h10, 64'hCAFE, 64'h0, 0, 0);
    run_op("load_0x10", 1, 0, 0, 0, 64'h10, 64'h0, 64'h0, 0, 0);
    run_op("load_0x43", 1, 0, 0, 0, 64'h43, 64'h0, 64'h0, 1, 1);

    // Reset while the load is in WAIT; the responder still answers afterwards.
    cfg_ready_dly = 0; cfg_resp_dly = 8; cfg_spurious = 0;
    exp_req_q.push_back('{we: 1'b0, addr: 64'h18, wdata: 64'h0});
    op_valid = 1'b1; MemRead = 1'b1; aluResult_M = 64'h18;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("wait_stall_before_reset", {63'd0, stall_M}, 1);
    op_valid = 1'b0; MemRead = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    check("async_rst_stall", {63'd0, stall_M}, 0);
    check("async_rst_req_valid", {63'd0, dm_req_valid}, 0);
    check("async_rst_read_data", readData_M, 0);
    check("async_rst_req_addr", dm_req_addr, 0);
    check("async_rst_rd_valid", {63'd0, rd_valid}, 0);
    @(negedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    repeat (14) @(posedge clk);
    #1;
    check("late_resp_ignored", readData_M, 0);
    check("late_resp_stall", {63'd0, stall_M}, 0);
    $display("op %0d reset_in_wait addr=0x18", op_num);
    op_num++;

    for (int i = 0; i < 120; i++) begin
      kind = $urandom_range(0, 3);
      a = 64'($urandom_range(0, 15)) << ADDR_LSB;
      if ($urandom_range(0, 7) == 0) a = a + 64'($urandom_range(1, 7));
      cfg_spurious = ($urandom_range(0, 1) == 1);
      run_op($sformatf("rand_%0d", i), kind == 1 || kind == 3, kind >= 2,
             $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
             a, {$urandom(), $urandom()}, {$urandom(), $urandom()},
             $urandom_range(0, 4), $urandom_range(0, 4));
    end

    cfg_spurious = 0;
    repeat (4) @(posedge clk);
    #1;
    timed_out = (exp_req_q.size() != 0) || (exp_rd_q.size() != 0);
    check("req_queue_drained", exp_req_q.size(), 0);
    check("rd_queue_drained", exp_rd_q.size(), 0);
    check("fault_count_drained", exp_fault_cnt, 0);
    if (timed_out) $display("note: %0d requests and %0d loads left outstanding", exp_req_q.size(), exp_rd_q.size());
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
